// File: rtl/wb_result_stage.sv
// wb_result_stage: registered writeback-source mux with RV32I load extraction and optional 1-cycle load alignment
//
// Ports:
//   clk, reset             rising-edge clock, asynchronous active-high reset
//   valid_in, stall, flush instruction valid and pipeline control (flush beats stall)
//   ALUResult              ALU result; bits [1:0] are the load byte offset
//   RD                     data-memory read word; sampled LOAD_LATENCY cycles after ALUResult
//   PCPlus4, ImmExt, PCTarget  non-ALU writeback sources
//   ResultSrc, Funct3      writeback source select and load type
//   RegWrite_in, Rd_in     destination write enable and index
//   Result, Rd_out         registered writeback value and destination
//   RegWrite_out           register-file write enable, already qualified by valid
//   valid_out              outputs describe a real instruction
module wb_result_stage #(
    parameter int unsigned       XLEN           = 32,
    parameter int unsigned       LOAD_LATENCY   = 0,
    parameter bit                SUPPRESS_X0    = 1'b1,
    parameter logic [XLEN-1:0]   DEFAULT_RESULT = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] ALUResult,
    input  logic [XLEN-1:0] RD,
    input  logic [XLEN-1:0] PCPlus4,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [2:0]      ResultSrc,
    input  logic [2:0]      Funct3,
    input  logic            RegWrite_in,
    input  logic [4:0]      Rd_in,
    output logic [XLEN-1:0] Result,
    output logic [4:0]      Rd_out,
    output logic            RegWrite_out,
    output logic            valid_out
);

    function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] w, input logic [2:0] f3,
                                                 input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        return f3 == 3'b000 ? {{24{b[7]}}, b} :
               f3 == 3'b001 ? {{16{h[15]}}, h} :
               f3 == 3'b010 ? w :
               f3 == 3'b100 ? {24'h0, b} :
               f3 == 3'b101 ? {16'h0, h} : DEFAULT_RESULT;
    endfunction

    logic [XLEN-1:0] nl_d;
    logic            s_valid;
    logic [2:0]      s_src;
    logic [2:0]      s_f3;
    logic [1:0]      s_off;
    logic            s_rw;
    logic [4:0]      s_rd;
    logic [XLEN-1:0] s_nl;

    // Non-load value is resolved up front so stage A only has to carry one word.
    always_comb begin
        nl_d = ResultSrc == 3'b000 ? ALUResult :
               ResultSrc == 3'b010 ? PCPlus4 :
               ResultSrc == 3'b011 ? ImmExt :
               ResultSrc == 3'b100 ? PCTarget : DEFAULT_RESULT;
    end

    if (LOAD_LATENCY == 1) begin : g_lat1
        logic            a_valid_q;
        logic [2:0]      a_src_q;
        logic [2:0]      a_f3_q;
        logic [1:0]      a_off_q;
        logic            a_rw_q;
        logic [4:0]      a_rd_q;
        logic [XLEN-1:0] a_nl_q;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                a_valid_q <= 1'b0;
                a_src_q   <= '0;
                a_f3_q    <= '0;
                a_off_q   <= '0;
                a_rw_q    <= 1'b0;
                a_rd_q    <= '0;
                a_nl_q    <= '0;
            end else if (flush) begin
                a_valid_q <= 1'b0;
            end else if (!stall) begin
                a_valid_q <= valid_in;
                a_src_q   <= ResultSrc;
                a_f3_q    <= Funct3;
                a_off_q   <= ALUResult[1:0];
                a_rw_q    <= RegWrite_in;
                a_rd_q    <= Rd_in;
                a_nl_q    <= nl_d;
            end
        end
        assign s_valid = a_valid_q;
        assign s_src   = a_src_q;
        assign s_f3    = a_f3_q;
        assign s_off   = a_off_q;
        assign s_rw    = a_rw_q;
        assign s_rd    = a_rd_q;
        assign s_nl    = a_nl_q;
    end else begin : g_lat0
        assign s_valid = valid_in;
        assign s_src   = ResultSrc;
        assign s_f3    = Funct3;
        assign s_off   = ALUResult[1:0];
        assign s_rw    = RegWrite_in;
        assign s_rd    = Rd_in;
        assign s_nl    = nl_d;
    end

    logic [XLEN-1:0] result_d, result_q;
    logic [4:0]      rd_q;
    logic            rw_d, rw_q;
    logic            valid_q;

    // RD is always taken live here: with LOAD_LATENCY=1 it lines up with the stage-A offset.
    always_comb begin
        result_d = s_src == 3'b001 ? load_ext(RD, s_f3, s_off) : s_nl;
        rw_d     = s_valid & s_rw & ~(SUPPRESS_X0 & (s_rd == 5'd0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            rd_q     <= '0;
            rw_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else if (flush) begin
            rw_q     <= 1'b0;
            valid_q  <= 1'b0;
        end else if (!stall) begin
            result_q <= result_d;
            rd_q     <= s_rd;
            rw_q     <= rw_d;
            valid_q  <= s_valid;
        end
    end

    assign Result       = result_q;
    assign Rd_out       = rd_q;
    assign RegWrite_out = rw_q;
    assign valid_out    = valid_q;

endmodule

// File: tb/tb_wb_result_stage.sv
// tb_wb_result_stage: directed checks of wb_result_stage at latency 0 and 1 and with x0 suppression off
module tb_wb_result_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
    logic [31:0] alu = '0, rd_word = '0, pc4 = '0, imm = '0, pct = '0;
    logic [2:0]  src = '0, f3 = '0;
    logic        rw_in = 1'b0;
    logic [4:0]  rd_in = '0;

    logic [31:0] res0, res1, res2;
    logic [4:0]  rdo0, rdo1, rdo2;
    logic        rw0, rw1, rw2, v0, v1, v2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wb_result_stage #(.LOAD_LATENCY(0), .SUPPRESS_X0(1'b1), .DEFAULT_RESULT(32'h0)) d0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
        .ALUResult(alu), .RD(rd_word), .PCPlus4(pc4), .ImmExt(imm), .PCTarget(pct),
        .ResultSrc(src), .Funct3(f3), .RegWrite_in(rw_in), .Rd_in(rd_in),
        .Result(res0), .Rd_out(rdo0), .RegWrite_out(rw0), .valid_out(v0));

    wb_result_stage #(.LOAD_LATENCY(1), .SUPPRESS_X0(1'b1), .DEFAULT_RESULT(32'h0)) d1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
        .ALUResult(alu), .RD(rd_word), .PCPlus4(pc4), .ImmExt(imm), .PCTarget(pct),
        .ResultSrc(src), .Funct3(f3), .RegWrite_in(rw_in), .Rd_in(rd_in),
        .Result(res1), .Rd_out(rdo1), .RegWrite_out(rw1), .valid_out(v1));

    wb_result_stage #(.LOAD_LATENCY(0), .SUPPRESS_X0(1'b0), .DEFAULT_RESULT(32'hDEAD_BEEF)) d2 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall), .flush(flush),
        .ALUResult(alu), .RD(rd_word), .PCPlus4(pc4), .ImmExt(imm), .PCTarget(pct),
        .ResultSrc(src), .Funct3(f3), .RegWrite_in(rw_in), .Rd_in(rd_in),
        .Result(res2), .Rd_out(rdo2), .RegWrite_out(rw2), .valid_out(v2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [2:0] f, input logic [31:0] a,
                         input logic [4:0] r, input logic w);
        valid_in = v; src = s; f3 = f; alu = a; rd_in = r; rw_in = w;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks++; if (res0 !== 32'h0) begin errors++; $display("FAIL reset_res0: got %h want %h", res0, 32'h0); end
        checks++; if ({rdo0, rw0, v0} !== 7'h0) begin errors++; $display("FAIL reset_ctl0: got %h want %h", {rdo0, rw0, v0}, 7'h0); end
        checks++; if (res1 !== 32'h0) begin errors++; $display("FAIL reset_res1: got %h want %h", res1, 32'h0); end
        checks++; if ({rdo1, rw1, v1} !== 7'h0) begin errors++; $display("FAIL reset_ctl1: got %h want %h", {rdo1, rw1, v1}, 7'h0); end
        #3 reset = 1'b0;
        step();
    endtask

    task automatic test_alu();
        drive(1'b1, 3'b000, 3'b000, 32'h1234_5678, 5'd5, 1'b1);
        step();
        checks++; if (res0 !== 32'h1234_5678) begin errors++; $display("FAIL alu_res0: got %h want %h", res0, 32'h1234_5678); end
        checks++; if (rdo0 !== 5'd5) begin errors++; $display("FAIL alu_rd0: got %0d want %0d", rdo0, 5); end
        checks++; if (rw0 !== 1'b1) begin errors++; $display("FAIL alu_rw0: got %b want 1", rw0); end
        checks++; if (v0 !== 1'b1) begin errors++; $display("FAIL alu_v0: got %b want 1", v0); end
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL alu_v1_early: got %b want 0", v1); end
        valid_in = 1'b0;
        step();
        checks++; if (res1 !== 32'h1234_5678) begin errors++; $display("FAIL alu_res1: got %h want %h", res1, 32'h1234_5678); end
        checks++; if ({rdo1, rw1, v1} !== {5'd5, 1'b1, 1'b1}) begin errors++; $display("FAIL alu_ctl1: got %h want %h", {rdo1, rw1, v1}, {5'd5, 1'b1, 1'b1}); end
        checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL alu_v0_idle: got %b want 0", v0); end
    endtask

    task automatic test_loads();
        logic [2:0]  lf[5];
        logic [1:0]  lo[5];
        logic [31:0] le[5];
        lf = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        lo = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
        le = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
        rd_word = 32'h80FF_7F01;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'b001, lf[i], 32'h0000_1000 | 32'(lo[i]), 5'(10 + i), 1'b1);
            step();
            valid_in = 1'b0;
            step();
            checks++; if (res1 !== le[i]) begin errors++; $display("FAIL load%0d_res1: got %h want %h", i, res1, le[i]); end
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 3'b001, lf[i], 32'h0000_2000 | 32'(lo[i]), 5'(10 + i), 1'b1);
            step();
            checks++; if (res0 !== le[i]) begin errors++; $display("FAIL b2b%0d_res0: got %h want %h", i, res0, le[i]); end
            if (i > 0) begin
                checks++; if (res1 !== le[i-1]) begin errors++; $display("FAIL b2b%0d_res1: got %h want %h", i - 1, res1, le[i-1]); end
                checks++; if ({rdo1, v1} !== {5'(9 + i), 1'b1}) begin errors++; $display("FAIL b2b%0d_ctl1: got %h want %h", i - 1, {rdo1, v1}, {5'(9 + i), 1'b1}); end
            end
        end
        valid_in = 1'b0;
        step();
        checks++; if (res1 !== le[4]) begin errors++; $display("FAIL b2b4_res1: got %h want %h", res1, le[4]); end
        drive(1'b1, 3'b001, 3'b011, 32'h0000_3000, 5'd4, 1'b1);
        step();
        checks++; if (res2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_f3_rsvd: got %h want %h", res2, 32'hDEAD_BEEF); end
        valid_in = 1'b0;
    endtask

    task automatic test_sources();
        logic [2:0]  ss[4];
        logic [31:0] se[4];
        ss = '{3'b010, 3'b011, 3'b100, 3'b111};
        se = '{32'h0000_0104, 32'hABCD_E000, 32'h0000_2000, 32'h0};
        pc4 = 32'h104; imm = 32'hABCD_E000; pct = 32'h2000;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ss[i], 3'b000, 32'h5555_AAAA, 5'd6, 1'b1);
            step();
            checks++; if (res0 !== se[i]) begin errors++; $display("FAIL src%0d_res0: got %h want %h", ss[i], res0, se[i]); end
            if (i > 0) begin
                checks++; if (res1 !== se[i-1]) begin errors++; $display("FAIL src%0d_res1: got %h want %h", ss[i-1], res1, se[i-1]); end
            end
        end
        checks++; if (res2 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL src7_default: got %h want %h", res2, 32'hDEAD_BEEF); end
        checks++; if (rw0 !== 1'b1) begin errors++; $display("FAIL src7_rw0: got %b want 1", rw0); end
        valid_in = 1'b0;
        step();
        checks++; if (res1 !== 32'h0) begin errors++; $display("FAIL src7_res1: got %h want %h", res1, 32'h0); end
    endtask

    task automatic test_x0();
        drive(1'b1, 3'b000, 3'b000, 32'h0000_0042, 5'd0, 1'b1);
        step();
        checks++; if ({v0, rw0} !== 2'b10) begin errors++; $display("FAIL x0_suppress: got v/rw=%b want 10", {v0, rw0}); end
        checks++; if ({v2, rw2} !== 2'b11) begin errors++; $display("FAIL x0_nosuppress: got v/rw=%b want 11", {v2, rw2}); end
        valid_in = 1'b0;
        step();
        checks++; if ({v1, rw1} !== 2'b10) begin errors++; $display("FAIL x0_suppress1: got v/rw=%b want 10", {v1, rw1}); end
    endtask

    task automatic test_stall();
        rd_word = 32'h80FF_7F01;
        drive(1'b1, 3'b000, 3'b000, 32'hAAAA_0001, 5'd7, 1'b1);
        step();
        drive(1'b1, 3'b001, 3'b000, 32'h0000_4003, 5'd9, 1'b1);
        step();
        stall = 1'b1;
        valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_word = 32'h1122_3344 + 32'(i) * 32'h4444_4444;
            step();
            checks++; if ({res1, rdo1, rw1, v1} !== {32'hAAAA_0001, 5'd7, 1'b1, 1'b1}) begin errors++; $display("FAIL stall%0d_out1: got %h want %h", i, {res1, rdo1, rw1, v1}, {32'hAAAA_0001, 5'd7, 1'b1, 1'b1}); end
            checks++; if ({res0, rdo0, v0} !== {32'hFFFF_FF80, 5'd9, 1'b1}) begin errors++; $display("FAIL stall%0d_out0: got %h want %h", i, {res0, rdo0, v0}, {32'hFFFF_FF80, 5'd9, 1'b1}); end
        end
        stall = 1'b0;
        rd_word = 32'h7F00_0000;
        step();
        checks++; if (res1 !== 32'h0000_007F) begin errors++; $display("FAIL stall_release_res1: got %h want %h", res1, 32'h0000_007F); end
        checks++; if ({rdo1, v1} !== {5'd9, 1'b1}) begin errors++; $display("FAIL stall_release_ctl1: got %h want %h", {rdo1, v1}, {5'd9, 1'b1}); end
    endtask

    task automatic test_flush();
        drive(1'b1, 3'b000, 3'b000, 32'h0000_0011, 5'd1, 1'b1);
        step();
        drive(1'b1, 3'b000, 3'b000, 32'h0000_0022, 5'd2, 1'b1);
        step();
        drive(1'b1, 3'b000, 3'b000, 32'h0000_0033, 5'd3, 1'b1);
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        valid_in = 1'b0;
        checks++; if ({v0, rw0, v1, rw1} !== 4'b0000) begin errors++; $display("FAIL flush_out: got %b want 0000", {v0, rw0, v1, rw1}); end
        step();
        checks++; if ({v1, rw1} !== 2'b00) begin errors++; $display("FAIL flush_stageA: got %b want 00", {v1, rw1}); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 3'b000, 3'b000, 32'h0BAD_F00D, 5'd8, 1'b1);
        step();
        step();
        checks++; if ({v0, v1} !== 2'b11) begin errors++; $display("FAIL areset_pre: got %b want 11", {v0, v1}); end
        valid_in = 1'b0;
        #2 reset = 1'b1;
        #1;
        checks++; if ({res0, rdo0, rw0, v0} !== 39'h0) begin errors++; $display("FAIL areset_out0: got %h want 0", {res0, rdo0, rw0, v0}); end
        checks++; if ({res1, rdo1, rw1, v1} !== 39'h0) begin errors++; $display("FAIL areset_out1: got %h want 0", {res1, rdo1, rw1, v1}); end
        #2 reset = 1'b0;
        step();
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL areset_inflight: got %b want 0", v1); end
        drive(1'b1, 3'b000, 3'b000, 32'hCAFE_0000, 5'd3, 1'b1);
        step();
        valid_in = 1'b0;
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL areset_lat: got %b want 0", v1); end
        step();
        checks++; if ({res1, rdo1, v1} !== {32'hCAFE_0000, 5'd3, 1'b1}) begin errors++; $display("FAIL areset_first: got %h want %h", {res1, rdo1, v1}, {32'hCAFE_0000, 5'd3, 1'b1}); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_loads();
        test_sources();
        test_x0();
        test_stall();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_result_stage.md
Name: wb_result_stage

Overview:
Registered, parametrised successor to the single-cycle ResultSrc multiplexer.
- Selects one of five writeback sources.
- Performs RV32I load-data extraction: byte/halfword select with sign or zero extension.
- Optionally aligns to a synchronous data memory with one cycle of read latency.
- Sits between the execute/memory logic and the register-file write port. Carries valid, rd and RegWrite alongside the result, with stall and flush control.

Parameters:
- XLEN, 32, datapath width; only 32 is supported (byte-lane logic is RV32).
- LOAD_LATENCY, 0, cycles between the address (ALUResult) and RD being valid; legal values 0 or 1.
- SUPPRESS_X0, 1, when 1, RegWrite_out is forced low whenever Rd_out == 0.
- DEFAULT_RESULT, 32'h0, value driven for reserved ResultSrc encodings.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  the current instruction's inputs are meaningful.
- stall  input  1  hold all stage registers.
- flush  input  1  invalidate all in-flight entries.
- ALUResult  input  XLEN  ALU output; also the load address (bits [1:0] are the byte offset).
- RD  input  XLEN  raw data-memory read word, aligned per LOAD_LATENCY.
- PCPlus4  input  XLEN  return address for jal/jalr.
- ImmExt  input  XLEN  extended immediate for lui.
- PCTarget  input  XLEN  PC+imm for auipc.
- ResultSrc  input  3  000 ALU, 001 load, 010 PCPlus4, 011 ImmExt, 100 PCTarget, 101-111 reserved.
- Funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- RegWrite_in  input  1  the instruction writes rd.
- Rd_in  input  5  destination register index.
- Result  output  XLEN  registered writeback value.
- Rd_out  output  5  registered destination register index.
- RegWrite_out  output  1  register-file write enable, already gated by valid.
- valid_out  output  1  Result, Rd_out and RegWrite_out describe a real instruction.

Behaviour:
- Reset is asynchronous and clears every register: Result=0, Rd_out=0, RegWrite_out=0, valid_out=0, and all internal stage-A registers including their valid bit.
- Latency from valid_in sampled to valid_out is 1+LOAD_LATENCY cycles, with throughput of one instruction per cycle.
- LOAD_LATENCY=0:
  - A single output register captures the selected and extracted value on each un-stalled edge.
  - RD is sampled in the same cycle as ALUResult.
- LOAD_LATENCY=1:
  - Stage A registers valid_in, ResultSrc, Funct3, ALUResult[1:0], RegWrite_in, Rd_in, and the pre-selected non-load value (ALU/PCPlus4/ImmExt/PCTarget/default).
  - On the next edge the output register selects between that pre-selected value and extracted RD, using the stage-A ResultSrc. RD is sampled in that cycle.
- Load extraction uses off = byte offset and little-endian lanes:
  - LB/LBU: byte RD[8*off+7 : 8*off].
  - LH/LHU: halfword RD[31:16] if off[1], else RD[15:0]; off[0] is ignored.
  - LW: RD unchanged.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Funct3 011/110/111 with a load yield DEFAULT_RESULT.
- Reserved ResultSrc values yield DEFAULT_RESULT with RegWrite unaffected.
- RegWrite_out = captured valid AND captured RegWrite AND NOT (SUPPRESS_X0 AND Rd==0).
  - Result is still updated when valid is low; consumers must qualify it with valid_out.
- Stall: every register holds its value, including valid_out and the RegWrite_out decision. Inputs, including RD, are ignored that cycle.
- Flush:
  - Clears the valid bit of every stage on the next edge, so valid_out=0 and RegWrite_out=0.
  - The instruction presented with flush is dropped.
  - Flush has priority over stall.
  - Data registers may update or hold; their contents are unspecified while invalid.
- Back-to-back loads to different offsets must each extract with their own captured offset and Funct3; there is no cross-instruction leakage.
- Reset asserted mid-stream discards all in-flight entries. The first valid_out after reset release corresponds to the first valid_in sampled after release.

Test Plan:
- Reset, then ResultSrc=000, ALUResult=32'h1234_5678, valid_in=1, Rd_in=5, RegWrite_in=1 -> one cycle later Result=32'h1234_5678, Rd_out=5, RegWrite_out=1, valid_out=1.
- LOAD_LATENCY=1, RD=32'h80FF_7F01:
  - LB off=3 -> Result=32'hFFFF_FF80, 2 cycles after issue.
  - LBU off=1 -> 32'h0000_007F.
  - LH off=2 -> 32'hFFFF_80FF.
  - LHU off=0 -> 32'h0000_7F01.
  - LW -> 32'h80FF_7F01.
  - Issue all five back-to-back; each must come out in order with no mixing.
- ResultSrc=010/011/100 with PCPlus4=32'h104, ImmExt=32'hABCD_E000, PCTarget=32'h2000 -> Result equals each respectively. ResultSrc=111 -> DEFAULT_RESULT.
- Rd_in=0, RegWrite_in=1, SUPPRESS_X0=1 -> valid_out=1, RegWrite_out=0. Repeat with SUPPRESS_X0=0 -> RegWrite_out=1.
- Stall for 3 cycles with a load in stage A while RD changes -> outputs frozen. On release the load extracts from RD sampled in the first un-stalled cycle.
- Stall and flush asserted together -> valid_out=0 the next cycle. Async reset pulsed mid-cycle -> all outputs 0 immediately, without waiting for clk.
